ps2_key_encoder: RTL and testbench

Converts the raw PS/2 set-2 scancode byte stream from the keyboard serial receiver into the 11-bit `ps2_key` event word that the core's keyboard decode consumes. The word is `{toggle, pressed, extended, code[7:0]}`. The block parses the E0 extended prefix, the F0 break prefix and the E1 Pause sequence. It discards protocol bytes and flips `toggle` once per completed key event. It sits between the PS/2 byte receiver and every consumer of `ps2_key`. Consumers detect new events by comparing `ps2_key[10]` against its previous value.

---
 rtl/ps2_key_encoder.sv | 189 ++++++++++++++++++
 tb/tb_ps2_key_encoder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_encoder.sv
// ----------------------------------------------------------------------------
// ps2_key_encoder
//
// Turns the PS/2 set-2 scancode byte stream coming from the serial receiver
// into the 11-bit ps2_key event word {toggle, pressed, extended, code[7:0]}.
// The block handles the E0 extended prefix, the F0 break prefix and the
// eight-byte E1 Pause sequence. It drops protocol/reserved bytes and abandons
// partial sequences that stall. Bit 10 (toggle) flips once per emitted event,
// so consumers can spot new events by edge-detecting it.
//
// Parameters:
//   TIMEOUT           idle cycles allowed inside a partial sequence
//   FILTER_FAKE_SHIFT 1 = suppress extended 0x12 / 0x59 (fake shifts)
//
// Ports:
//   clk_sys     in   1  system clock, rising edge
//   reset_n     in   1  synchronous active-low reset
//   byte_valid  in   1  one-cycle strobe, byte_data holds a scancode byte
//   byte_data   in   8  received byte
//   ps2_key     out 11  {toggle, pressed, extended, code}
//   key_strobe  out  1  pulses in the cycle ps2_key updates
//   err_strobe  out  1  pulses when a byte is discarded or a sequence aborts
//   busy        out  1  high whenever the parser is not in IDLE
// ----------------------------------------------------------------------------
module ps2_key_encoder #(
    parameter int TIMEOUT           = 24000,
    parameter bit FILTER_FAKE_SHIFT = 1'b1
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [10:0] ps2_key,
    output logic        key_strobe,
    output logic        err_strobe,
    output logic        busy
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_MAX = CW'(TIMEOUT - 1);

    localparam logic [7:0] PFX_EXT   = 8'hE0;
    localparam logic [7:0] PFX_BRK   = 8'hF0;
    localparam logic [7:0] PFX_PAUSE = 8'hE1;
    localparam logic [7:0] PAUSE_CODE = 8'h77;

    typedef enum logic [2:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK,
        PAUSE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] tmo_q, tmo_d;
    logic [2:0]    skip_q, skip_d;
    logic [10:0]   ps2_key_q, ps2_key_d;
    logic          key_strobe_q, key_strobe_d;
    logic          err_strobe_q, err_strobe_d;

    // Candidate event produced by the byte parser, before the fake-shift filter.
    logic          emit;
    logic          ev_pressed;
    logic          ev_extended;
    logic [7:0]    ev_code;
    logic          is_reserved;
    logic          is_fake_shift;

    assign is_reserved = byte_data inside {8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE, 8'hEE};

    // NOTE: every signal written in this block is given a default first, so
    // no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        tmo_d        = tmo_q;
        skip_d       = skip_q;
        ps2_key_d    = ps2_key_q;
        key_strobe_d = 1'b0;
        err_strobe_d = 1'b0;
        emit         = 1'b0;
        ev_pressed   = 1'b0;
        ev_extended  = 1'b0;
        ev_code      = byte_data;

        if (byte_valid) begin
            // A byte always restarts the idle timer, even in the expiry cycle.
            tmo_d = '0;
            if (is_reserved) begin
                state_d      = IDLE;
                err_strobe_d = 1'b1;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (byte_data == PFX_EXT) begin
                            state_d = EXT;
                        end else if (byte_data == PFX_BRK) begin
                            state_d = BRK;
                        end else if (byte_data == PFX_PAUSE) begin
                            state_d = PAUSE;
                            skip_d  = 3'd7;
                        end else begin
                            emit       = 1'b1;
                            ev_pressed = 1'b1;
                        end
                    end
                    EXT: begin
                        if (byte_data == PFX_BRK) begin
                            state_d = EXT_BRK;
                        end else begin
                            state_d     = IDLE;
                            emit        = 1'b1;
                            ev_pressed  = 1'b1;
                            ev_extended = 1'b1;
                        end
                    end
                    BRK: begin
                        state_d = IDLE;
                        emit    = 1'b1;
                    end
                    EXT_BRK: begin
                        state_d     = IDLE;
                        emit        = 1'b1;
                        ev_extended = 1'b1;
                    end
                    PAUSE: begin
                        // Pause bytes (including E0/E1/F0) are only counted;
                        // the whole sequence collapses into one make event.
                        skip_d = skip_q - 3'd1;
                        if (skip_q == 3'd1) begin
                            state_d     = IDLE;
                            emit        = 1'b1;
                            ev_pressed  = 1'b1;
                            ev_extended = 1'b1;
                            ev_code     = PAUSE_CODE;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end else if (state_q != IDLE) begin
            if (tmo_q == TMO_MAX) begin
                state_d      = IDLE;
                tmo_d        = '0;
                err_strobe_d = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        // Fake shifts wrapped around extended keys are dropped silently: the
        // state has already returned to IDLE, there is just no event.
        is_fake_shift = FILTER_FAKE_SHIFT && ev_extended &&
                        (ev_code == 8'h12 || ev_code == 8'h59);

        if (emit && !is_fake_shift) begin
            ps2_key_d    = {~ps2_key_q[10], ev_pressed, ev_extended, ev_code};
            key_strobe_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values computed before this edge, independent of statement order.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            tmo_q        <= '0;
            skip_q       <= '0;
            ps2_key_q    <= '0;
            key_strobe_q <= 1'b0;
            err_strobe_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            skip_q       <= skip_d;
            ps2_key_q    <= ps2_key_d;
            key_strobe_q <= key_strobe_d;
            err_strobe_q <= err_strobe_d;
        end
    end

    assign ps2_key    = ps2_key_q;
    assign key_strobe = key_strobe_q;
    assign err_strobe = err_strobe_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_key_encoder.sv
// ----------------------------------------------------------------------------
// tb_ps2_key_encoder
//
// Self-checking bench for ps2_key_encoder. A table of single-cycle vectors
// {reset_n, byte_valid, byte_data -> ps2_key, key_strobe, err_strobe, busy}
// is applied one clock at a time; every expected word is hand-computed,
// including the running toggle bit. Timeout behaviour is exercised with
// hand-written sequences afterwards.
// ----------------------------------------------------------------------------
module tb_ps2_key_encoder;

    localparam int TIMEOUT = 16;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic [10:0] ps2_key;
    logic        key_strobe;
    logic        err_strobe;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk_sys = ~clk_sys;

    ps2_key_encoder #(
        .TIMEOUT          (TIMEOUT),
        .FILTER_FAKE_SHIFT(1'b1)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .ps2_key   (ps2_key),
        .key_strobe(key_strobe),
        .err_strobe(err_strobe),
        .busy      (busy)
    );

    typedef struct packed {
        logic        rst_n;
        logic        valid;
        logic [7:0]  data;
        logic [10:0] key;
        logic        ks;
        logic        err;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst_n, input logic valid, input logic [7:0] data,
                                input logic [10:0] key, input logic ks, input logic err,
                                input logic bsy);
        vec_t v;
        v.rst_n = rst_n;
        v.valid = valid;
        v.data  = data;
        v.key   = key;
        v.ks    = ks;
        v.err   = err;
        v.busy  = bsy;
        vecs.push_back(v);
    endfunction

    // Applies one cycle of input, then samples the registered outputs 1 ns
    // after the edge that consumed it.
    task automatic step(input logic rst_n, input logic valid, input logic [7:0] data);
        reset_n    = rst_n;
        byte_valid = valid;
        byte_data  = data;
        @(posedge clk_sys);
        #1;
        reset_n    = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
    endtask

    task automatic check(input string name, input logic [10:0] key, input logic ks,
                         input logic err, input logic bsy);
        checks++;
        if (ps2_key !== key || key_strobe !== ks || err_strobe !== err || busy !== bsy) begin
            errors++;
            $display("FAIL %s: got key=%03h ks=%b err=%b busy=%b, expected key=%03h ks=%b err=%b busy=%b",
                     name, ps2_key, key_strobe, err_strobe, busy, key, ks, err, bsy);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;

        //   rst  v   data     key     ks  err busy
        add(1'b0, 0, 8'h00, 11'h000, 0, 0, 0);   // reset state
        add(1'b1, 1, 8'h1C, 11'h61C, 1, 0, 0);   // plain make 'A'
        add(1'b1, 0, 8'h00, 11'h61C, 0, 0, 0);   // strobe lasts one cycle, key holds
        add(1'b1, 1, 8'hE0, 11'h61C, 0, 0, 1);   // extended break of 75
        add(1'b1, 1, 8'hF0, 11'h61C, 0, 0, 1);
        add(1'b1, 1, 8'h75, 11'h175, 1, 0, 0);
        add(1'b1, 1, 8'hE0, 11'h175, 0, 0, 1);   // fake shift make, filtered
        add(1'b1, 1, 8'h12, 11'h175, 0, 0, 0);
        add(1'b1, 1, 8'hE0, 11'h175, 0, 0, 1);   // extended make 7C
        add(1'b1, 1, 8'h7C, 11'h77C, 1, 0, 0);
        add(1'b1, 1, 8'hE0, 11'h77C, 0, 0, 1);   // fake shift break, filtered
        add(1'b1, 1, 8'hF0, 11'h77C, 0, 0, 1);
        add(1'b1, 1, 8'h12, 11'h77C, 0, 0, 0);
        add(1'b1, 1, 8'hE1, 11'h77C, 0, 0, 1);   // Pause: E1 14 77 E1 F0 14 F0 77
        add(1'b1, 1, 8'h14, 11'h77C, 0, 0, 1);
        add(1'b1, 1, 8'h77, 11'h77C, 0, 0, 1);
        add(1'b1, 1, 8'hE1, 11'h77C, 0, 0, 1);
        add(1'b1, 1, 8'hF0, 11'h77C, 0, 0, 1);
        add(1'b1, 1, 8'h14, 11'h77C, 0, 0, 1);
        add(1'b1, 1, 8'hF0, 11'h77C, 0, 0, 1);
        add(1'b1, 1, 8'h77, 11'h377, 1, 0, 0);
        add(1'b1, 1, 8'hF0, 11'h377, 0, 0, 1);   // plain break 1C
        add(1'b1, 1, 8'h1C, 11'h41C, 1, 0, 0);
        add(1'b1, 1, 8'hAA, 11'h41C, 0, 1, 0);   // reserved byte in IDLE
        add(1'b1, 1, 8'hE0, 11'h41C, 0, 0, 1);   // reserved byte in EXT
        add(1'b1, 1, 8'hFA, 11'h41C, 0, 1, 0);
        add(1'b1, 1, 8'hF0, 11'h41C, 0, 0, 1);   // reset mid-sequence
        add(1'b0, 0, 8'h00, 11'h000, 0, 0, 0);
        add(1'b1, 1, 8'h16, 11'h616, 1, 0, 0);
        add(1'b1, 1, 8'hE1, 11'h616, 0, 0, 1);   // reserved byte inside PAUSE
        add(1'b1, 1, 8'h00, 11'h616, 0, 1, 0);
        add(1'b1, 1, 8'hE0, 11'h616, 0, 0, 1);   // fake shift 59, filtered
        add(1'b1, 1, 8'h59, 11'h616, 0, 0, 0);
        add(1'b1, 1, 8'hF0, 11'h616, 0, 0, 1);   // reserved byte in BRK
        add(1'b1, 1, 8'hFF, 11'h616, 0, 1, 0);
        add(1'b1, 1, 8'hE0, 11'h616, 0, 0, 1);   // reserved byte in EXT_BRK
        add(1'b1, 1, 8'hF0, 11'h616, 0, 0, 1);
        add(1'b1, 1, 8'hEE, 11'h616, 0, 1, 0);
        add(1'b1, 1, 8'h1C, 11'h21C, 1, 0, 0);   // back-to-back makes
        add(1'b1, 1, 8'h32, 11'h632, 1, 0, 0);
        add(1'b1, 1, 8'hE0, 11'h632, 0, 0, 1);   // E0 after E0 is an extended code
        add(1'b1, 1, 8'hE0, 11'h3E0, 1, 0, 0);

        step(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst_n, vecs[i].valid, vecs[i].data);
            check($sformatf("vec[%0d] data=%02h", i, vecs[i].data),
                  vecs[i].key, vecs[i].ks, vecs[i].err, vecs[i].busy);
        end

        // Timeout: E0 then silence. Busy for TIMEOUT-1 idle cycles, then the
        // sequence is abandoned with an error pulse on the next one.
        step(1'b1, 1'b1, 8'hE0);
        check("tmo_start", 11'h3E0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i < TIMEOUT; i++) begin
            step(1'b1, 1'b0, 8'h00);
            check($sformatf("tmo_wait[%0d]", i), 11'h3E0, 1'b0, 1'b0, 1'b1);
        end
        step(1'b1, 1'b0, 8'h00);
        check("tmo_expire", 11'h3E0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'h00);
        check("tmo_err_one_cycle", 11'h3E0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h29);
        check("tmo_next_make", 11'h629, 1'b1, 1'b0, 1'b0);

        // Byte arriving in the expiry cycle wins over the timeout.
        step(1'b1, 1'b1, 8'hE0);
        for (int i = 1; i < TIMEOUT; i++) begin
            step(1'b1, 1'b0, 8'h00);
        end
        check("race_before", 11'h629, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'hF0);
        check("race_byte_wins", 11'h629, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'h75);
        check("race_ext_break", 11'h175, 1'b1, 1'b0, 1'b0);

        // Timeout also abandons a Pause sequence with no event.
        step(1'b1, 1'b1, 8'hE1);
        step(1'b1, 1'b1, 8'h14);
        for (int i = 1; i < TIMEOUT; i++) begin
            step(1'b1, 1'b0, 8'h00);
        end
        step(1'b1, 1'b0, 8'h00);
        check("pause_tmo", 11'h175, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'h77);
        check("pause_tmo_then_make", 11'h677, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
